// File: rtl/bus_arbiter8.sv
// Round-robin arbiter/sequencer steering eight 16-bit requesters onto one registered bus.
// Owners keep the path for a burst; release re-arbitrates in the same cycle so grants are bubble-free.
module bus_arbiter8 #(
  parameter int MAX_BURST = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [7:0]   REQ,
  input  logic [7:0]   LAST,
  input  logic [127:0] DIN,
  output logic [7:0]   GNT,
  output logic [2:0]   SEL,
  output logic [15:0]  OUT,
  output logic         VALID,
  output logic         BUSY
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t      state_q, state_d;
  logic [7:0]  gnt_q, gnt_d;
  logic [2:0]  sel_q, sel_d;
  logic [15:0] out_q, out_d;
  logic        valid_q, valid_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [2:0]  owner;
  logic [15:0] lane;
  logic        xfer;
  logic        burst_end;
  logic [3:0]  idle_win;
  logic [3:0]  rel_win;

  // Returns {found, index} of the first requester scanning ptr, ptr+1, ... mod 8.
  function automatic logic [3:0] arb(input logic [7:0] req, input logic [2:0] ptr);
    logic [3:0] r;
    logic [2:0] idx;
    r = 4'b0;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr + 3'(k);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign owner     = sel_q;
  assign lane      = DIN[{owner, 4'b0000} +: 16];
  assign xfer      = REQ[owner];
  assign burst_end = ({1'b0, cnt_q} + 9'd1) == 9'(MAX_BURST);
  assign idle_win  = arb(REQ, ptr_q);
  // The releasing owner sits last in this scan, so it only wins when nobody else asks.
  assign rel_win   = arb(REQ, owner + 3'd1);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    out_d   = out_q;
    valid_d = 1'b0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (idle_win[3]) begin
          state_d = OWN;
          gnt_d   = 8'b0000_0001 << idle_win[2:0];
          sel_d   = idle_win[2:0];
          cnt_d   = 8'd0;
        end
      end
      OWN: begin
        if (xfer) begin
          out_d   = lane;
          valid_d = 1'b1;
        end
        if (!xfer || LAST[owner] || burst_end) begin
          ptr_d = owner + 3'd1;
          cnt_d = 8'd0;
          if (rel_win[3]) begin
            gnt_d = 8'b0000_0001 << rel_win[2:0];
            sel_d = rel_win[2:0];
          end else begin
            state_d = IDLE;
            gnt_d   = 8'd0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      gnt_q   <= 8'd0;
      sel_q   <= 3'd0;
      out_q   <= 16'd0;
      valid_q <= 1'b0;
      ptr_q   <= 3'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign GNT   = gnt_q;
  assign SEL   = sel_q;
  assign OUT   = out_q;
  assign VALID = valid_q;
  assign BUSY  = (state_q == OWN);

endmodule

// File: tb/tb_bus_arbiter8.sv
// Bench for bus_arbiter8: two instances (burst limits 4 and 2) driven in lock step
// and compared every cycle against a transaction-level arbitration model.
module tb_bus_arbiter8;
  localparam int NI   = 2;
  localparam int LIM0 = 4;
  localparam int LIM1 = 2;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic                 RESET;
  logic [7:0]           REQ, LAST;
  logic [127:0]         DIN;
  logic [NI-1:0][7:0]   gnt;
  logic [NI-1:0][2:0]   sel;
  logic [NI-1:0][15:0]  dout;
  logic [NI-1:0]        valid, busy;

  int checks, errors;

  bus_arbiter8 #(.MAX_BURST(LIM0)) u0 (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .LAST(LAST), .DIN(DIN),
    .GNT(gnt[0]), .SEL(sel[0]), .OUT(dout[0]), .VALID(valid[0]), .BUSY(busy[0])
  );
  bus_arbiter8 #(.MAX_BURST(LIM1)) u1 (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .LAST(LAST), .DIN(DIN),
    .GNT(gnt[1]), .SEL(sel[1]), .OUT(dout[1]), .VALID(valid[1]), .BUSY(busy[1])
  );

  // Reference model: current owner (-1 when idle), pointer, beats taken, last outputs.
  int          m_own [NI];
  int          m_ptr [NI];
  int          m_cnt [NI];
  int          m_sel [NI];
  logic [15:0] m_out [NI];
  logic        m_vld [NI];

  function automatic int lim(int k);
    return (k == 0) ? LIM0 : LIM1;
  endfunction

  function automatic int winner(logic [7:0] r, int p);
    for (int j = 0; j < 8; j++)
      if (r[(p + j) % 8]) return (p + j) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_own[k] = -1; m_ptr[k] = 0; m_cnt[k] = 0;
      m_sel[k] = 0;  m_out[k] = 16'h0; m_vld[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      int o, w;
      bit rel;
      rel = 1'b0;
      if (m_own[k] < 0) begin
        m_vld[k] = 1'b0;
        w = winner(REQ, m_ptr[k]);
        if (w >= 0) begin m_own[k] = w; m_sel[k] = w; m_cnt[k] = 0; end
      end else begin
        o = m_own[k];
        if (REQ[o]) begin
          m_out[k] = DIN[16*o +: 16];
          m_vld[k] = 1'b1;
          if (LAST[o] || (m_cnt[k] + 1 == lim(k))) rel = 1'b1;
          else m_cnt[k]++;
        end else begin
          m_vld[k] = 1'b0;
          rel = 1'b1;
        end
        if (rel) begin
          m_ptr[k] = (o + 1) % 8;
          w = winner(REQ, m_ptr[k]);
          m_own[k] = w;
          if (w >= 0) begin m_sel[k] = w; m_cnt[k] = 0; end
        end
      end
    end
  endtask

  function automatic logic [28:0] exp_vec(int k);
    logic [7:0] g;
    g = (m_own[k] >= 0) ? 8'(1 << m_own[k]) : 8'h00;
    return {g, 3'(m_sel[k]), m_out[k], m_vld[k], (m_own[k] >= 0)};
  endfunction

  function automatic logic [28:0] obs_vec(int k);
    return {gnt[k], sel[k], dout[k], valid[k], busy[k]};
  endfunction

  task automatic step();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    REQ = 8'h00; LAST = 8'h00;
    #2 RESET = 1'b1;
    #1 model_reset();
    @(posedge CLK);
    #2 RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; REQ = 8'h00; LAST = 8'h00; DIN = '0;
    model_reset();
    #12;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (obs_vec(k) !== 29'h0) begin
        errors++; $display("FAIL reset_state u%0d: got %h expected 0", k, obs_vec(k));
      end
    end
    @(posedge CLK);
    #2 RESET = 1'b0;
  endtask

  task automatic test_single();
    int nv;
    nv = 0;
    REQ = 8'h04; LAST = 8'h00;
    DIN = {$urandom, $urandom, $urandom, $urandom};
    DIN[47:32] = 16'hBEEF;
    for (int c = 1; c <= 6; c++) begin
      step();
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++; $display("FAIL single c%0d u%0d: got %h expected %h", c, k, obs_vec(k), exp_vec(k));
        end
      end
      if (valid[0]) begin
        nv++;
        checks++;
        if (dout[0] !== 16'hBEEF) begin
          errors++; $display("FAIL single_data: got %h expected beef", dout[0]);
        end
      end
      if (c == 1) begin
        checks++;
        if (gnt[0] !== 8'h04 || sel[0] !== 3'd2) begin
          errors++; $display("FAIL single_grant: got gnt %h sel %0d expected 04/2", gnt[0], sel[0]);
        end
      end
      if (c == 3) LAST = 8'h04;
      if (c == 4) begin REQ = 8'h00; LAST = 8'h00; end
    end
    checks++;
    if (nv != 3 || gnt[0] !== 8'h00) begin
      errors++; $display("FAIL single_beats: got %0d beats gnt %h expected 3 beats gnt 00", nv, gnt[0]);
    end
    // Pointer now at 3: requester 0 must beat requester 2.
    REQ = 8'h05;
    step();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (gnt[k] !== 8'h01 || sel[k] !== 3'd0) begin
        errors++; $display("FAIL single_ptr u%0d: got gnt %h sel %0d expected 01/0", k, gnt[k], sel[k]);
      end
    end
  endtask

  task automatic test_fairness();
    do_reset();
    REQ = 8'hFF; LAST = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      step();
      DIN = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++; $display("FAIL fair i%0d u%0d: got %h expected %h", i, k, obs_vec(k), exp_vec(k));
        end
        checks++;
        if (sel[k] !== 3'(i % 8) || gnt[k] !== 8'(1 << (i % 8)) || (i >= 1 && valid[k] !== 1'b1)) begin
          errors++; $display("FAIL fair_seq i%0d u%0d: got sel %0d gnt %h vld %b expected sel %0d", i, k, sel[k], gnt[k], valid[k], i % 8);
        end
      end
    end
  endtask

  task automatic test_burst_limit();
    int es;
    do_reset();
    REQ = 8'h03; LAST = 8'h00;
    for (int c = 1; c <= 10; c++) begin
      step();
      DIN = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++; $display("FAIL burst c%0d u%0d: got %h expected %h", c, k, obs_vec(k), exp_vec(k));
        end
      end
      es = (c >= 5 && c <= 8) ? 1 : 0;
      checks++;
      if (sel[0] !== 3'(es) || busy[0] !== 1'b1 || valid[0] !== (c >= 2)) begin
        errors++; $display("FAIL burst_seq c%0d: got sel %0d busy %b vld %b expected sel %0d", c, sel[0], busy[0], valid[0], es);
      end
    end
  endtask

  task automatic test_drop();
    do_reset();
    REQ = 8'h20; LAST = 8'h00;
    DIN = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 1; c <= 5; c++) begin
      step();
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++; $display("FAIL drop c%0d u%0d: got %h expected %h", c, k, obs_vec(k), exp_vec(k));
        end
        if (c == 4) begin
          checks++;
          if (gnt[k] !== 8'h40 || sel[k] !== 3'd6 || valid[k] !== 1'b0) begin
            errors++; $display("FAIL drop_handover u%0d: got gnt %h sel %0d vld %b expected 40/6/0", k, gnt[k], sel[k], valid[k]);
          end
        end
      end
      if (c == 3) REQ = 8'h40;
    end
  endtask

  task automatic test_sole();
    do_reset();
    REQ = 8'h10; LAST = 8'h00;
    for (int c = 1; c <= 10; c++) begin
      step();
      DIN = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++; $display("FAIL sole c%0d u%0d: got %h expected %h", c, k, obs_vec(k), exp_vec(k));
        end
        checks++;
        if (gnt[k] !== 8'h10 || valid[k] !== (c >= 2)) begin
          errors++; $display("FAIL sole_hold c%0d u%0d: got gnt %h vld %b expected 10", c, k, gnt[k], valid[k]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    REQ = 8'h08; LAST = 8'h00;
    DIN = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 1; c <= 3; c++) step();
    #2 RESET = 1'b1;
    #1 model_reset();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (obs_vec(k) !== 29'h0) begin
        errors++; $display("FAIL async_reset u%0d: got %h expected 0", k, obs_vec(k));
      end
    end
    REQ = 8'h80;
    @(posedge CLK);
    #2 RESET = 1'b0;
    step();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (gnt[k] !== 8'h80 || sel[k] !== 3'd7 || obs_vec(k) !== exp_vec(k)) begin
        errors++; $display("FAIL async_regrant u%0d: got %h expected %h", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) REQ = 8'($urandom);
      LAST = 8'($urandom & $urandom);
      DIN  = {$urandom, $urandom, $urandom, $urandom};
      step();
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++; $display("FAIL random c%0d u%0d: got %h expected %h", c, k, obs_vec(k), exp_vec(k));
        end
        checks++;
        if (($countones(gnt[k]) > 1) || (gnt[k] != 0 && !gnt[k][sel[k]]) || (busy[k] !== (gnt[k] != 0))) begin
          errors++; $display("FAIL invariant c%0d u%0d: got gnt %h sel %0d busy %b", c, k, gnt[k], sel[k], busy[k]);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_fairness();
    test_burst_limit();
    test_drop();
    test_sole();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
